// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// serialiser, with bit timing from a CLK_HZ/BAUD_RATE down-counter.
module uart_tx #(
    parameter int CLK_HZ    = 65_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic       done_out
);
    localparam int          DIV       = CLK_HZ / BAUD_RATE;
    localparam logic [15:0] DIV_M1    = 16'(DIV - 1);
    localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    // state | meaning
    // IDLE  | line high, waiting for the holding register to fill
    // START | start bit (low)
    // DATA  | data bits, LSB first
    // PAR   | parity bit
    // STOP  | stop bit(s), high; last cycle may chain straight into START
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_full_q, hold_full_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        bit_end;
    logic        load;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= DIV_M1;
            shift_q     <= 8'h00;
            hold_data_q <= 8'h00;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        parity_d    = parity_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        load        = 1'b0;
        bit_end     = (cnt_q == 16'd0);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? DIV_M1 : cnt_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        if (PARITY != 0) begin
                            tx_d    = parity_q;
                            state_d = PAR;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Held data is already masked, so parity covers only the used bits.
        if (load) begin
            state_d     = START;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
            cnt_d       = DIV_M1;
            shift_d     = hold_data_q;
            parity_d    = (^hold_data_q) ^ (PARITY == 1);
            hold_full_d = 1'b0;
        end else if (valid_in && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = data_in & DATA_MASK;
        end
    end

    assign ready_out = !hold_full_q;
    assign tx_out    = tx_q;
    assign busy_out  = busy_q;
    assign done_out  = (state_q == STOP) && bit_end && (stop_cnt_q == LAST_STOP);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances in different frame formats, checked against
// per-cycle line traces built from a bit-list model of each frame.
module tb_uart_tx;
    localparam int DIV   = 10;
    localparam int DB[4] = '{8, 8, 8, 5};
    localparam int PB[4] = '{0, 2, 1, 0};
    localparam int SB[4] = '{1, 1, 1, 2};

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic [3:0] rst, valid, ready, tx, busy, done;
    logic [7:0] din[4];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx #(
            .CLK_HZ(1_000_000), .BAUD_RATE(100_000),
            .DATA_BITS(DB[g]), .PARITY(PB[g]), .STOP_BITS(SB[g])
        ) dut (
            .clk_in(clk), .rst_in(rst[g]), .data_in(din[g]), .valid_in(valid[g]),
            .ready_out(ready[g]), .tx_out(tx[g]), .busy_out(busy[g]), .done_out(done[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line bits of one frame, one entry per bit period.
    function automatic int frame_bits(input int u, input logic [7:0] b, output logic [15:0] bits);
        int n;
        int ones;
        bits = '1;
        bits[0] = 1'b0;
        n = 1;
        ones = 0;
        for (int i = 0; i < DB[u]; i++) begin
            bits[n] = b[i];
            ones += int'(b[i]);
            n++;
        end
        if (PB[u] == 2) begin
            bits[n] = 1'(ones % 2);
            n++;
        end else if (PB[u] == 1) begin
            bits[n] = 1'(1 - ones % 2);
            n++;
        end
        for (int i = 0; i < SB[u]; i++) begin
            bits[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    // Index 0 is the accept cycle; frames follow back to back from index 1.
    task automatic build_exp(input int u, input byte_q_t q,
                             output logic [511:0] etx, output logic [511:0] ebusy,
                             output logic [511:0] edone);
        logic [15:0] bits;
        int n;
        int c;
        etx = '1;
        ebusy = '0;
        edone = '0;
        c = 1;
        foreach (q[k]) begin
            n = frame_bits(u, q[k], bits);
            for (int i = 0; i < n * DIV; i++) begin
                etx[c] = bits[i / DIV];
                ebusy[c] = 1'b1;
                c++;
            end
            edone[c - 1] = 1'b1;
        end
    endtask

    // Offers the queued bytes with valid held high; while ready is low data_in is scrambled.
    task automatic do_run(input int u, input byte_q_t q, input string tag,
                          output logic [511:0] atx, output logic [511:0] abusy,
                          output logic [511:0] aready);
        logic [511:0] adone, etx, ebusy, edone;
        logic acc;
        int idx;
        idx = 0;
        for (int j = 0; j < 512; j++) begin
            if (idx < q.size()) begin
                valid[u] = 1'b1;
                din[u] = ready[u] ? q[idx] : 8'($urandom);
            end else begin
                valid[u] = 1'b0;
                din[u] = 8'($urandom);
            end
            acc = valid[u] && ready[u];
            tick();
            if (acc) idx++;
            atx[j] = tx[u];
            abusy[j] = busy[u];
            adone[j] = done[u];
            aready[j] = ready[u];
        end
        valid[u] = 1'b0;
        build_exp(u, q, etx, ebusy, edone);
        chk({tag, "_tx"}, atx, etx);
        chk({tag, "_busy"}, abusy, ebusy);
        chk({tag, "_done"}, adone, edone);
    endtask

    initial begin
        byte_q_t q;
        logic [511:0] atx, abusy, aready;

        rst = 4'hF;
        valid = 4'h0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        tick();
        tick();
        rst = 4'h0;
        tick();
        chk("reset_tx", 512'(tx), 512'hF);
        chk("reset_busy", 512'(busy), 512'h0);
        chk("reset_done", 512'(done), 512'h0);
        chk("reset_ready", 512'(ready), 512'hF);

        q.delete(); q.push_back(8'h55);
        do_run(0, q, "8n1_55", atx, abusy, aready);
        chk("8n1_start_after_accept", 512'(atx[1]), 512'(0));
        chk("8n1_ready_after_accept", 512'(aready[0]), 512'(0));
        chk("8n1_ready_after_load", 512'(aready[1]), 512'(1));

        q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
        do_run(0, q, "b2b", atx, abusy, aready);
        chk("b2b_ready_after_load", 512'(aready[1]), 512'(1));
        chk("b2b_second_accept", 512'(aready[2]), 512'(0));
        chk("b2b_busy_200", abusy[200:1], {200{1'b1}});

        q.delete(); q.push_back(8'h07); q.push_back(8'hA5);
        do_run(1, q, "8e1", atx, abusy, aready);
        chk("8e1_parity_07", 512'(atx[91]), 512'(1));
        chk("8e1_parity_a5", 512'(atx[201]), 512'(0));

        q.delete(); q.push_back(8'h07);
        do_run(2, q, "8o1", atx, abusy, aready);
        chk("8o1_parity_07", 512'(atx[91]), 512'(0));

        q.delete(); q.push_back(8'hFF);
        do_run(3, q, "5n2", atx, abusy, aready);
        chk("5n2_stop_high", 512'(atx[80:61]), 512'hFFFFF);
        chk("5n2_busy_end", 512'(abusy[81:80]), 512'(2'b01));

        for (int u = 0; u < 4; u++) begin
            q.delete();
            for (int k = 0; k < 3; k++) q.push_back(8'($urandom));
            do_run(u, q, $sformatf("rand%0d", u), atx, abusy, aready);
        end

        valid[0] = 1'b1;
        din[0] = 8'h00;
        tick();
        din[0] = 8'($urandom);
        tick();
        tick();
        valid[0] = 1'b0;
        repeat (43) tick();
        chk("rstmid_in_data_bit3", 512'({tx[0], busy[0], ready[0]}), 512'(3'b010));
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("rstmid_after", 512'({tx[0], busy[0], ready[0], done[0]}), 512'(4'b1010));
        q.delete();
        do_run(0, q, "rstmid_quiet", atx, abusy, aready);

        q.delete(); q.push_back(8'($urandom));
        do_run(0, q, "post_reset", atx, abusy, aready);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
